// File: rtl/sort_cell_param.sv
// Compare-and-pass insertion-sort cell: keeps the winning element of a frame,
// forwards the losers and flushes the survivor tagged last at end of frame.
// Frame control follows ap_ctrl_chain so cells can be cascaded behind start FIFOs.
module sort_cell_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SIGNED   = 1,
    parameter int unsigned KEEP_MAX = 1,
    parameter int unsigned MAX_LEN  = 256,
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    input  logic              ap_continue,
    input  logic              start_full_n,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              start_out,
    output logic              start_write,
    input  logic [DATA_W-1:0] in_dout,
    input  logic              in_last,
    input  logic              in_empty_n,
    output logic              in_read,
    output logic [DATA_W-1:0] out_din,
    output logic              out_last,
    input  logic              out_full_n,
    output logic              out_write,
    output logic [CNT_W-1:0]  frame_len
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   held_q, held_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    frame_len_q, frame_len_d;
    logic                done_reg_q, done_reg_d;
    logic                start_once_q, start_once_d;

    logic                real_start;
    logic                win;
    logic                frame_end;
    logic [CNT_W-1:0]    cnt_next;
    logic                done_pulse;
    logic                ready_pulse;

    // Start is suppressed only while the downstream start FIFO is full and
    // this frame's start token has not been written yet.
    assign real_start = (!start_full_n && !start_once_q) ? 1'b0 : ap_start;

    // cnt never exceeds MAX_LEN-1 before this increment, so it cannot wrap.
    assign cnt_next  = cnt_q + CNT_W'(1);
    assign frame_end = in_last || (cnt_next == CNT_W'(MAX_LEN));

    // Strict comparison of the incoming element against the held one.
    always_comb begin
        logic gt;
        logic lt;
        if (SIGNED != 0) begin
            gt = $signed(in_dout) > $signed(held_q);
            lt = $signed(in_dout) < $signed(held_q);
        end else begin
            gt = in_dout > held_q;
            lt = in_dout < held_q;
        end
        win = (KEEP_MAX != 0) ? gt : lt;
    end

    // Next-state, datapath updates and FIFO/handshake strobes.
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        cnt_d       = cnt_q;
        frame_len_d = frame_len_q;
        in_read     = 1'b0;
        out_write   = 1'b0;
        out_din     = held_q;
        out_last    = 1'b0;
        done_pulse  = 1'b0;
        ready_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (real_start && !done_reg_q) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                end
            end
            S_FILL: begin
                if (in_empty_n) begin
                    in_read = 1'b1;
                    held_d  = in_dout;
                    cnt_d   = CNT_W'(1);
                    if (frame_end) begin
                        state_d     = S_FLUSH;
                        ready_pulse = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (in_empty_n && out_full_n) begin
                    in_read   = 1'b1;
                    out_write = 1'b1;
                    if (win) begin
                        out_din = held_q;
                        held_d  = in_dout;
                    end else begin
                        out_din = in_dout;
                    end
                    cnt_d = cnt_next;
                    if (frame_end) begin
                        state_d     = S_FLUSH;
                        ready_pulse = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (out_full_n) begin
                    out_write   = 1'b1;
                    out_din     = held_q;
                    out_last    = 1'b1;
                    frame_len_d = cnt_q;
                    done_pulse  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky done and start-token bookkeeping for ap_ctrl_chain.
    always_comb begin
        done_reg_d = done_reg_q;
        if (ap_continue) begin
            done_reg_d = 1'b0;
        end else if (done_pulse) begin
            done_reg_d = 1'b1;
        end
        start_once_d = start_once_q;
        if (ready_pulse) begin
            start_once_d = 1'b0;
        end else if (real_start) begin
            start_once_d = 1'b1;
        end
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= S_IDLE;
            held_q       <= '0;
            cnt_q        <= '0;
            frame_len_q  <= '0;
            done_reg_q   <= 1'b0;
            start_once_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            cnt_q        <= cnt_d;
            frame_len_q  <= frame_len_d;
            done_reg_q   <= done_reg_d;
            start_once_q <= start_once_d;
        end
    end

    assign ap_done     = done_pulse | done_reg_q;
    assign ap_ready    = ready_pulse;
    assign ap_idle     = (state_q == S_IDLE) && !real_start;
    assign start_out   = real_start;
    assign start_write = real_start && !start_once_q;
    assign frame_len   = frame_len_q;

endmodule

// File: doc/sort_cell_param.md
# sort_cell_param

Parametrised compare-and-pass cell for the FIFO-connected insertion-sort dataflow chain. It holds one element per frame. Each incoming element is compared against the held one: the cell keeps the winner and forwards the loser. At end of frame it flushes the held element tagged `last`. This is the next-generation cell: configurable width, signedness, sort direction and frame bound, with explicit frame delimiting and ap_ctrl_chain start propagation so N instances can be cascaded behind start FIFOs.

## Interface
- `DATA_W`, default 32: element width in bits.
- `SIGNED`, default 1: 1 = two's-complement compare, 0 = unsigned compare.
- `KEEP_MAX`, default 1: 1 = retain larger and forward smaller; 0 = retain smaller and forward larger.
- `MAX_LEN`, default 256: maximum elements per frame (≥1). `CNT_W = clog2(MAX_LEN+1)`.
- `ap_clk`  in  1  sole clock; all state changes on rising edge.
- `ap_rst_n`  in  1  reset, synchronous, active-low.
- `ap_start`, `ap_continue`, `start_full_n`  in  1  ap_ctrl_chain inputs.
- `ap_done`, `ap_idle`, `ap_ready`, `start_out`, `start_write`  out  1  ap_ctrl_chain outputs.
- `in_dout`  in  DATA_W  input FIFO head (first-word-fall-through).
- `in_last`  in  1  marks final element of the frame; valid with `in_dout`.
- `in_empty_n`  in  1  input FIFO non-empty.
- `in_read`  out  1  pop strobe.
- `out_din`  out  DATA_W  forwarded element.
- `out_last`  out  1  end-of-frame marker to downstream cell.
- `out_full_n`  in  1  output FIFO not full.
- `out_write`  out  1  push strobe.
- `frame_len`  out  CNT_W  element count of the most recently completed frame.

## Operation
- `real_start = (start_full_n==0 && start_once_reg==0) ? 0 : ap_start`. `start_out = real_start`. `start_write = real_start && !start_once_reg`. `start_once_reg` sets on `real_start && !ap_ready` and clears on `ap_ready`.
- `win(a,b)` is true when a is strictly greater than b (KEEP_MAX=1) or strictly less (KEEP_MAX=0), using signed/unsigned compare per SIGNED. Ties forward the input and keep the held value.
- `held`, `cnt` registers. `end = in_last || (cnt+1 == MAX_LEN)`.
- **IDLE**: waits for `real_start && !ap_done_reg`, then goes to FILL with `cnt` = 0. No strobes.
- **FILL**: on `in_empty_n`, pulse `in_read` and load `held <= in_dout`, `cnt <= 1`. If `end`, go to FLUSH and pulse `ap_ready`; otherwise go to RUN. Nothing is written.
- **RUN**: the fire condition is `in_empty_n && out_full_n`. When it fires, pulse both `in_read` and `out_write` in the same cycle.
  - If `win(in_dout, held)`, set `out_din = held` and `held <= in_dout`.
  - Otherwise set `out_din = in_dout`.
  - `out_last = 0`; `cnt <= cnt+1`.
  - If `end`: go to FLUSH and pulse `ap_ready`.
- **FLUSH**: on `out_full_n`, pulse `out_write` with `out_din = held`, `out_last = 1`. Also `frame_len <= cnt`, pulse `ap_done`, and go to IDLE. If `ap_continue` is 0, set `ap_done_reg` (held until `ap_continue` = 1). `ap_done = pulse | ap_done_reg`.
- A frame ending by MAX_LEN truncation flushes normally. The next element then begins a new frame.
- `ap_idle = (state==IDLE) && !real_start`.
- Output element count per frame equals input count. `out_last` appears exactly once per frame.
- `out_din` is don't-care when `out_write` = 0. `in_read` and `out_write` are never asserted without `in_empty_n` / `out_full_n` respectively.

## Timing
- Reset values: state IDLE; `held`, `cnt`, `frame_len` = 0; `ap_done_reg`, `start_once_reg` = 0.
  - Strobes, `ap_done` and `ap_ready` are 0.
  - `ap_idle` = 1 when `ap_start` = 0.
- Strobes are combinational from the current state and FIFO flags. Data is accepted on the same edge.
- An N-element frame with no stalls takes N+1 cycles from the first `in_read` to the `out_last` write (FILL 1, RUN N−1, FLUSH 1).
- IDLE→FILL costs one cycle. The next frame's FILL never overlaps FLUSH.
- RUN stalls, with no state or `cnt` change, if either FIFO flag is low. A read never occurs without a write.
- Deasserting `ap_rst_n` mid-frame discards `held` and `cnt` next edge. No flush is emitted.
- `ap_done_reg` = 1 blocks the IDLE→FILL transition even with `ap_start` = 1.

## Test plan
- Sort direction, signed: DATA_W=32, SIGNED=1, KEEP_MAX=1, frame [5, −3, 7, 2(last)] -> out −3, 5, 2, 7(last); `frame_len` = 4; `ap_done` pulse in the flush cycle.
- Sort direction, unsigned: same frame, SIGNED=0 -> out 5, 7, 2, 0xFFFFFFFD(last).
- Descending variant and ties: KEEP_MAX=0, frame [4, 4, 9, 1(last)] -> out 4, 9, 4, 1(last).
- Backpressure: `out_full_n` low for 3 cycles mid-RUN -> no `in_read` during the stall; output sequence unchanged.
- Frame bounds:
  - Single-element frame [42(last)] -> one write of 42 with `out_last`.
  - MAX_LEN=3 with 5 elements and no `in_last` -> two frames of 3 and 2 items, with `out_last` after the 3rd item; the second frame's `out_last` needs a terminating `in_last`.
- Handshake and reset:
  - `ap_continue` = 0 after done -> `ap_done` stays high and the next frame waits; pulsing `ap_continue` releases it.
  - `ap_rst_n` low after 2 RUN elements -> IDLE, no `out_last`, outputs at reset values.
